n1_pbus_mem: RTL

//  Responder (slave) end of the N1 program bus (pipelined Wishbone).

---
 rtl/n1_pbus_mem.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/n1_pbus_mem.sv
// N1 program bus responder: pipelined Wishbone slave in front of a word-addressed
// RAM, answering queued requests in order after a fixed latency.
module n1_pbus_mem #(
  parameter int ADR_WIDTH  = 14,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        async_rst_n_i,
  input  logic        sync_rst_i,
  input  logic        pbus_cyc_i,
  input  logic        pbus_stb_i,
  input  logic        pbus_we_i,
  input  logic [15:0] pbus_adr_i,
  input  logic [15:0] pbus_dat_i,
  input  logic        pbus_tga_prog_i,
  input  logic        rty_inject_i,
  output logic        pbus_stall_o,
  output logic        pbus_ack_o,
  output logic        pbus_err_o,
  output logic        pbus_rty_o,
  output logic [15:0] pbus_dat_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0]       LAT      = 3'(LATENCY);
  localparam logic [3:0]       LAT_W4   = 4'(LATENCY);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic             BYPASS_EN = 1'(LATENCY == 1);

  // tga_prog only matters at acceptance, where it is folded into err.
  typedef struct packed {
    logic                 we;
    logic [ADR_WIDTH-1:0] adr;
    logic [15:0]          dat;
    logic                 rty;
    logic                 err;
  } req_t;

  function automatic logic req_err(input logic [15:0] adr, input logic we, input logic tga);
    return (|(adr >> ADR_WIDTH)) | (we & tga);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  logic [15:0]      mem_r [0:(2**ADR_WIDTH)-1];
  req_t             fifo_r [FIFO_DEPTH];
  logic [2:0]       age_r  [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             stall_r, ack_r, err_r, rty_r;
  logic [15:0]      dat_r;

  req_t             in_req_s, head_s, resp_req_s;
  logic             accept_s, head_valid_s, head_ready_s, issue_head_s, bypass_s;
  logic             enq_s, resp_valid_s, resp_ack_s, mem_we_s;
  logic [CNT_W-1:0] count_nxt_s;

  // Request decode, response selection and occupancy update.
  always_comb begin
    in_req_s.we  = pbus_we_i;
    in_req_s.adr = pbus_adr_i[ADR_WIDTH-1:0];
    in_req_s.dat = pbus_dat_i;
    in_req_s.rty = rty_inject_i;
    in_req_s.err = req_err(pbus_adr_i, pbus_we_i, pbus_tga_prog_i);
    head_s       = fifo_r[rd_ptr_r];

    accept_s     = pbus_cyc_i & pbus_stb_i & ~stall_r;
    head_valid_s = (count_r != {CNT_W{1'b0}});
    // Head is issued one edge before its age reaches LATENCY so the registered
    // response lands exactly in that cycle.
    head_ready_s = (({1'b0, age_r[rd_ptr_r]} + 4'd1) >= LAT_W4);
    issue_head_s = pbus_cyc_i & head_valid_s & head_ready_s;
    // With LATENCY 1 a request into an empty queue is answered straight away.
    bypass_s     = accept_s & ~head_valid_s & BYPASS_EN;
    enq_s        = accept_s & ~bypass_s;
    resp_valid_s = issue_head_s | bypass_s;

    if (issue_head_s) begin
      resp_req_s = head_s;
    end else begin
      resp_req_s = in_req_s;
    end
    resp_ack_s = resp_valid_s & ~resp_req_s.err & ~resp_req_s.rty;
    mem_we_s   = resp_ack_s & resp_req_s.we & async_rst_n_i & ~sync_rst_i;

    if (!pbus_cyc_i) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (enq_s && !issue_head_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (issue_head_s && !enq_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Queue control and registered bus responses.
  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      count_r  <= {CNT_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      stall_r  <= 1'b0;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      rty_r    <= 1'b0;
      dat_r    <= 16'h0000;
    end else if (sync_rst_i) begin
      count_r  <= {CNT_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      stall_r  <= 1'b0;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      rty_r    <= 1'b0;
      dat_r    <= 16'h0000;
    end else begin
      count_r <= count_nxt_s;
      stall_r <= (count_nxt_s == DEPTH_C);
      if (!pbus_cyc_i) begin
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (enq_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
        if (issue_head_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      ack_r <= resp_ack_s;
      err_r <= resp_valid_s & resp_req_s.err;
      rty_r <= resp_valid_s & ~resp_req_s.err & resp_req_s.rty;
      dat_r <= (resp_ack_s && !resp_req_s.we) ? mem_r[resp_req_s.adr] : 16'h0000;
    end
  end

  // Queue payload and per-entry age counters.
  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_r[i] <= '0;
        age_r[i]  <= 3'd0;
      end
    end else if (sync_rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_r[i] <= '0;
        age_r[i]  <= 3'd0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (enq_s && (wr_ptr_r == PTR_W'(i))) begin
          fifo_r[i] <= in_req_s;
          age_r[i]  <= 3'd1;
        end else if (age_r[i] < LAT) begin
          age_r[i] <= age_r[i] + 3'd1;
        end
      end
    end
  end

  // Program RAM; contents survive reset and change only on an acked write.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) mem_r[resp_req_s.adr] <= resp_req_s.dat;
  end

  assign pbus_stall_o = stall_r;
  assign pbus_ack_o   = ack_r;
  assign pbus_err_o   = err_r;
  assign pbus_rty_o   = rty_r;
  assign pbus_dat_o   = dat_r;

endmodule
